reg_dl: RTL and testbench

Input data latch for the 6502-compatible CPU core. It captures the byte present on the external data pins and hands it to one or more of three internal buses: the data bus (DB), address-low bus (ADL) and address-high bus (ADH). Each bus output is a holding register that keeps its last transferred value until that bus is enabled again. The block sits between the memory data input and the internal bus multiplexing.

---
 rtl/reg_dl_pkg.sv | 12 +
 rtl/reg_dl_bus_hold_reg.sv | 32 +++
 rtl/reg_dl.sv | 54 +++++
 tb/tb_reg_dl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reg_dl_pkg.sv
// rtl/reg_dl_pkg.sv - shared CPU constants for the data latch and bus outputs
package reg_dl_pkg;

    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        BUS_DB  = 2'd0,
        BUS_ADL = 2'd1,
        BUS_ADH = 2'd2
    } bus_sel_e;

endpackage

// File: rtl/reg_dl_bus_hold_reg.sv
// rtl/reg_dl_bus_hold_reg.sv - enable-gated holding register with sync active-low reset
module bus_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/reg_dl.sv
// rtl/reg_dl.sv - input data latch feeding the DB, ADL and ADH internal buses
module reg_dl
    import reg_dl_pkg::*;
#(
    parameter int WIDTH = CPU_DATA_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD,
    input  logic             DB_BUS_ENABLE,
    input  logic             ADL_BUS_ENABLE,
    input  logic             ADH_BUS_ENABLE,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] DB_OUT,
    output logic [WIDTH-1:0] ADL_OUT,
    output logic [WIDTH-1:0] ADH_OUT
);

    logic [WIDTH-1:0] dl;

    bus_hold_reg #(.WIDTH(WIDTH)) u_dl (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (LOAD),
        .d     (DATA),
        .q     (dl)
    );

    // Bus registers sample the pre-edge latch value, so a same-edge LOAD is not bypassed.
    bus_hold_reg #(.WIDTH(WIDTH)) u_db (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (DB_BUS_ENABLE),
        .d     (dl),
        .q     (DB_OUT)
    );

    bus_hold_reg #(.WIDTH(WIDTH)) u_adl (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (ADL_BUS_ENABLE),
        .d     (dl),
        .q     (ADL_OUT)
    );

    bus_hold_reg #(.WIDTH(WIDTH)) u_adh (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (ADH_BUS_ENABLE),
        .d     (dl),
        .q     (ADH_OUT)
    );

endmodule

// File: tb/tb_reg_dl.sv
// tb/tb_reg_dl.sv - randomized and directed bench for reg_dl against a behavioural model
module tb_reg_dl;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       db_en;
    logic       adl_en;
    logic       adh_en;
    logic [7:0] data;
    logic [7:0] db_out;
    logic [7:0] adl_out;
    logic [7:0] adh_out;

    int vectors;
    int miscompares;

    logic [7:0] dl_m;
    logic [7:0] bus_m [3];

    reg_dl #(.WIDTH(8)) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .LOAD           (load),
        .DB_BUS_ENABLE  (db_en),
        .ADL_BUS_ENABLE (adl_en),
        .ADH_BUS_ENABLE (adh_en),
        .DATA           (data),
        .DB_OUT         (db_out),
        .ADL_OUT        (adl_out),
        .ADH_OUT        (adh_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge: drive, advance the model using pre-edge state, sample 1ns after the edge.
    task automatic step(input logic r, input logic ld, input logic e_db, input logic e_adl,
                        input logic e_adh, input logic [7:0] d);
        logic [2:0] en;
        rst_n  = r;
        load   = ld;
        db_en  = e_db;
        adl_en = e_adl;
        adh_en = e_adh;
        data   = d;
        en     = {e_adh, e_adl, e_db};
        @(posedge clk);
        if (!r) begin
            dl_m = 8'h00;
            for (int i = 0; i < 3; i++) bus_m[i] = 8'h00;
        end else begin
            for (int i = 0; i < 3; i++) if (en[i]) bus_m[i] = dl_m;
            if (ld) dl_m = d;
        end
        #1;
        rst_n = 1'b1; load = 1'b0; db_en = 1'b0; adl_en = 1'b0; adh_en = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (db_out !== 8'h00) begin miscompares++; $display("FAIL reset_db got %h exp 00", db_out); end
            vectors++;
            if (adl_out !== 8'h00) begin miscompares++; $display("FAIL reset_adl got %h exp 00", adl_out); end
            vectors++;
            if (adh_out !== 8'h00) begin miscompares++; $display("FAIL reset_adh got %h exp 00", adh_out); end
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        end
    endtask

    task automatic test_sequential();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (db_out !== 8'hAA) begin miscompares++; $display("FAIL seq_db got %h exp AA", db_out); end
        vectors++;
        if (adl_out !== 8'h00 || adh_out !== 8'h00) begin
            miscompares++; $display("FAIL seq_others got %h/%h exp 00/00", adl_out, adh_out);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBB);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        vectors++;
        if (adl_out !== 8'hBB || db_out !== 8'hAA) begin
            miscompares++; $display("FAIL seq_adl got adl %h db %h exp BB AA", adl_out, db_out);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCC);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        vectors++;
        if (adh_out !== 8'hCC || db_out !== 8'hAA || adl_out !== 8'hBB) begin
            miscompares++;
            $display("FAIL seq_adh got %h/%h/%h exp AA/BB/CC", db_out, adl_out, adh_out);
        end
    endtask

    task automatic test_load_no_enable();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        vectors++;
        if (db_out !== 8'hAA || adl_out !== 8'hBB || adh_out !== 8'hCC) begin
            miscompares++;
            $display("FAIL load_hold got %h/%h/%h exp AA/BB/CC", db_out, adl_out, adh_out);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (db_out !== 8'h55) begin miscompares++; $display("FAIL load_then_db got %h exp 55", db_out); end
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
        vectors++;
        if (db_out !== 8'h11) begin miscompares++; $display("FAIL collision_db got %h exp 11", db_out); end
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        vectors++;
        if (db_out !== 8'h22) begin miscompares++; $display("FAIL collision_next got %h exp 22", db_out); end
    endtask

    task automatic test_broadcast();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        vectors++;
        if (db_out !== 8'h7E || adl_out !== 8'h7E || adh_out !== 8'h7E) begin
            miscompares++;
            $display("FAIL broadcast got %h/%h/%h exp 7E/7E/7E", db_out, adl_out, adh_out);
        end
    endtask

    task automatic test_reset_priority();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        vectors++;
        if (db_out !== 8'h00 || adl_out !== 8'h00 || adh_out !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_prio got %h/%h/%h exp 00/00/00", db_out, adl_out, adh_out);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
        vectors++;
        if (adl_out !== 8'h00) begin miscompares++; $display("FAIL rst_prio_latch got %h exp 00", adl_out); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom));
            vectors++;
            if (db_out !== bus_m[0]) begin
                miscompares++; $display("FAIL rand_db n=%0d got %h exp %h", n, db_out, bus_m[0]);
            end
            vectors++;
            if (adl_out !== bus_m[1]) begin
                miscompares++; $display("FAIL rand_adl n=%0d got %h exp %h", n, adl_out, bus_m[1]);
            end
            vectors++;
            if (adh_out !== bus_m[2]) begin
                miscompares++; $display("FAIL rand_adh n=%0d got %h exp %h", n, adh_out, bus_m[2]);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        dl_m = 8'h00;
        for (int i = 0; i < 3; i++) bus_m[i] = 8'h00;
        rst_n = 1'b0; load = 1'b0; db_en = 1'b0; adl_en = 1'b0; adh_en = 1'b0; data = 8'h00;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_sequential();
        test_load_no_enable();
        test_collision();
        test_broadcast();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
